// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencing controller for the 4-LED pattern datapath.
// Owns pattern select, position, step prescaler and the MANUAL/AUTO/HOLD
// state machine, and arbitrates the debounced UP/DOWN/MODE button pulses.
// Optional feature: define LED_SEQ_SPEED_EN to add a 2-bit speed register
// (adjusted with UP/DOWN while in HOLD) that shortens the step period.
module led_seq_ctrl #(
  parameter int TICK_W = 23,
  parameter int DWELL  = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_MODE,
  output logic [1:0] PAT,
  output logic [2:0] POS,
  output logic       STEP,
  output logic [1:0] MODE
);

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_AUTO   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  state_t              state, state_nxt;
  logic [1:0]          pat, pat_nxt;
  logic [2:0]          pos, pos_nxt;
  logic                step, step_nxt;
  logic [TICK_W-1:0]   presc, presc_nxt;
  logic [DW_W-1:0]     dwell, dwell_nxt;
  logic [TICK_W-1:0]   step_mask;
  logic                step_fire;
  logic                up_ev, dn_ev;

`ifdef LED_SEQ_SPEED_EN
  logic [1:0]          spd, spd_nxt;
`else
  localparam logic [1:0] spd = 2'd0;
`endif

  // Next pattern going forward through ping-pong, left, right.
  function automatic logic [1:0] pat_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Previous pattern (0 wraps back to 2).
  function automatic logic [1:0] pat_dec(input logic [1:0] p);
    return (p == 2'd0) ? 2'd2 : p - 2'd1;
  endfunction

  // Advance position, wrapping at the pattern's last position.
  function automatic logic [2:0] pos_step(input logic [1:0] p, input logic [2:0] q);
    logic [2:0] last;
    last = (p == 2'd0) ? 3'd5 : 3'd3;
    return (q == last) ? 3'd0 : q + 3'd1;
  endfunction

`ifdef LED_SEQ_SPEED_EN
  // Saturating speed adjust: UP toward 3, DOWN toward 0.
  function automatic logic [1:0] spd_sat(input logic [1:0] s, input logic inc, input logic dec);
    logic [1:0] r;
    r = s;
    if (inc && s != 2'd3) r = s + 2'd1;
    else if (dec && s != 2'd0) r = s - 2'd1;
    return r;
  endfunction
`endif

  // UP/DOWN together cancel; MODE overrides both.
  assign up_ev = BTN_UP   && !BTN_DOWN && !BTN_MODE;
  assign dn_ev = BTN_DOWN && !BTN_UP   && !BTN_MODE;

  // A step needs only the low TICK_W-SPD prescaler bits to be ones.
  assign step_mask = {TICK_W{1'b1}} >> spd;
  assign step_fire = (state != S_HOLD) && (&(presc | ~step_mask));

  // State register: all control and position state, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_MANUAL;
      pat   <= 2'd0;
      pos   <= 3'd0;
      step  <= 1'b0;
      presc <= '0;
      dwell <= '0;
`ifdef LED_SEQ_SPEED_EN
      spd   <= 2'd0;
`endif
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      pos   <= pos_nxt;
      step  <= step_nxt;
      presc <= presc_nxt;
      dwell <= dwell_nxt;
`ifdef LED_SEQ_SPEED_EN
      spd   <= spd_nxt;
`endif
    end
  end

  // Next-state: stepping first, then button arbitration overrides it.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    pos_nxt   = pos;
    step_nxt  = 1'b0;
    presc_nxt = presc;
    dwell_nxt = dwell;
`ifdef LED_SEQ_SPEED_EN
    spd_nxt   = spd;
`endif

    if (state != S_HOLD) begin
      presc_nxt = presc + TICK_W'(1);
      if (step_fire) begin
        step_nxt = 1'b1;
        if (state == S_AUTO && dwell == DWELL_LAST) begin
          pat_nxt   = pat_inc(pat);
          pos_nxt   = 3'd0;
          dwell_nxt = '0;
          presc_nxt = '0;
        end else begin
          pos_nxt = pos_step(pat, pos);
          if (state == S_AUTO) dwell_nxt = dwell + DW_W'(1);
        end
      end
    end

    if (BTN_MODE) begin
      unique case (state)
        S_MANUAL: begin
          state_nxt = S_AUTO;
          dwell_nxt = '0;
        end
        S_AUTO:   state_nxt = S_HOLD;
        default:  state_nxt = S_MANUAL;
      endcase
    end else if (state == S_HOLD) begin
`ifdef LED_SEQ_SPEED_EN
      spd_nxt = spd_sat(spd, up_ev, dn_ev);
`endif
    end else if (up_ev || dn_ev) begin
      // A manual pattern change restarts the pattern and drops AUTO.
      state_nxt = S_MANUAL;
      pat_nxt   = up_ev ? pat_inc(pat) : pat_dec(pat);
      pos_nxt   = 3'd0;
      presc_nxt = '0;
      step_nxt  = 1'b0;
      dwell_nxt = dwell;
    end
  end

  assign PAT  = pat;
  assign POS  = pos;
  assign STEP = step;
  assign MODE = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl (TICK_W=3, DWELL=4).
// Stimulus pushes the reference model's expected post-edge outputs into a
// queue; a monitor pops one entry per clock edge and compares.
module tb_led_seq_ctrl;

  localparam int TICK_W = 3;
  localparam int DWELL  = 4;

  logic       CLK = 1'b0;
  logic       RST, BTN_UP, BTN_DOWN, BTN_MODE;
  logic [1:0] PAT;
  logic [2:0] POS;
  logic       STEP;
  logic [1:0] MODE;

  led_seq_ctrl #(.TICK_W(TICK_W), .DWELL(DWELL)) dut (
    .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
    .BTN_MODE(BTN_MODE), .PAT(PAT), .POS(POS), .STEP(STEP), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] pat;
    logic [2:0] pos;
    logic       step;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 0;

  // Reference state: plain integers following the behavioural rules.
  int m_mode, m_pat, m_pos, m_step, m_cnt, m_dwell, m_spd;
  int pat_len[3] = '{6, 4, 4};

  task automatic model_reset();
    m_mode = 0; m_pat = 0; m_pos = 0; m_step = 0;
    m_cnt = 0; m_dwell = 0; m_spd = 0;
  endtask

  // Time passing in MANUAL/AUTO: count one cycle, maybe take a step.
  task automatic model_run();
    int period;
    period = 1 << ((m_spd >= TICK_W) ? 0 : (TICK_W - m_spd));
    if ((m_cnt % period) != period - 1) begin
      m_cnt = (m_cnt + 1) % (1 << TICK_W);
    end else if (m_mode == 1 && m_dwell == DWELL - 1) begin
      m_pat = (m_pat + 1) % 3; m_pos = 0; m_dwell = 0; m_cnt = 0; m_step = 1;
    end else begin
      m_pos = (m_pos + 1) % pat_len[m_pat];
      if (m_mode == 1) m_dwell++;
      m_cnt = (m_cnt + 1) % (1 << TICK_W);
      m_step = 1;
    end
  endtask

  task automatic model_edge(input bit r, input bit u, input bit d, input bit m);
    bit uev, dev;
    if (r) begin
      model_reset();
      return;
    end
    uev = u && !d && !m;
    dev = d && !u && !m;
    m_step = 0;
    if (m) begin
      if (m_mode != 2) model_run();
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_dwell = 0;
    end else if (m_mode == 2) begin
`ifdef LED_SEQ_SPEED_EN
      if (uev && m_spd < 3) m_spd++;
      if (dev && m_spd > 0) m_spd--;
`endif
    end else if (uev || dev) begin
      m_pat  = (m_pat + (uev ? 1 : 2)) % 3;
      m_pos  = 0;
      m_cnt  = 0;
      m_mode = 0;
    end else begin
      model_run();
    end
  endtask

  // Drive one clock of inputs and queue the expected result of that edge.
  task automatic cyc(input bit r, input bit u, input bit d, input bit m);
    exp_t e;
    @(negedge CLK);
    RST = r; BTN_UP = u; BTN_DOWN = d; BTN_MODE = m;
    model_edge(r, u, d, m);
    e.pat  = 2'(m_pat);
    e.pos  = 3'(m_pos);
    e.step = 1'(m_step);
    e.mode = 2'(m_mode);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic pulse(input bit u, input bit d, input bit m, input int gap);
    cyc(0, u, d, m);
    idle(gap);
  endtask

  // Monitor: outputs are presented every edge; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({PAT, POS, STEP, MODE} !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t: got PAT=%0d POS=%0d STEP=%0d MODE=%0d, want PAT=%0d POS=%0d STEP=%0d MODE=%0d",
                   $time, PAT, POS, STEP, MODE, e.pat, e.pos, e.step, e.mode);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized segments.
  initial begin
    int dens;
    RST = 1'b1; BTN_UP = 1'b0; BTN_DOWN = 1'b0; BTN_MODE = 1'b0;
    model_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    idle(56);
    // Pattern selection in MANUAL
    pulse(1, 0, 0, 3);
    pulse(1, 0, 0, 3);
    pulse(1, 0, 0, 3);
    pulse(0, 1, 0, 3);
    pulse(1, 1, 0, 3);
    pulse(1, 0, 0, 40);
    // AUTO rotation, then UP drops back to MANUAL
    cyc(1, 0, 0, 0);
    pulse(0, 0, 1, 70);
    pulse(1, 0, 0, 10);
    // HOLD freeze and resume
    pulse(0, 0, 1, 5);
    pulse(0, 0, 1, 100);
    pulse(0, 0, 1, 20);
    // Speed adjust in HOLD (ignored unless the feature is built in)
    pulse(0, 0, 1, 2);
    pulse(0, 0, 1, 2);
    for (int i = 0; i < 5; i++) pulse(1, 0, 0, 1);
    pulse(0, 0, 1, 20);
    pulse(0, 0, 1, 2);
    pulse(0, 0, 1, 2);
    for (int i = 0; i < 4; i++) pulse(0, 1, 0, 1);
    pulse(0, 0, 1, 20);
    // MODE together with UP/DOWN, and reset while in AUTO
    pulse(1, 0, 1, 27);
    cyc(1, 0, 0, 0);
    idle(20);
    // Randomized segments with varying button density
    for (int s = 0; s < 80; s++) begin
      dens = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) begin
        bit r, u, d, m;
        r = ($urandom_range(0, 999) == 0);
        case (dens)
          0: begin u = 0; d = 0; m = 0; end
          1: begin u = ($urandom_range(0, 99) == 0); d = ($urandom_range(0, 99) == 0);
                   m = ($urandom_range(0, 99) == 0); end
          2: begin u = ($urandom_range(0, 29) == 0); d = ($urandom_range(0, 29) == 0);
                   m = ($urandom_range(0, 49) == 0); end
          default: begin u = ($urandom_range(0, 5) == 0); d = ($urandom_range(0, 5) == 0);
                   m = ($urandom_range(0, 7) == 0); end
        endcase
        cyc(r, u, d, m);
      end
    end
    @(negedge CLK);
    BTN_UP = 0; BTN_DOWN = 0; BTN_MODE = 0;
    repeat (2) @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
